// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller:
// FSM states, ALU codes, opcodes and datapath select values.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_JWB,
    S_LUI,
    S_AUIPC,
    S_TRAP
  } state_t;

  typedef enum logic [1:0] {
    CLS_ADD,
    CLS_R,
    CLS_I,
    CLS_BR
  } op_class_t;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_PASSB = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLL   = 4'b0101;
  localparam logic [3:0] ALU_SRL   = 4'b0110;
  localparam logic [3:0] ALU_SRA   = 4'b0111;
  localparam logic [3:0] ALU_SUB   = 4'b1000;
  localparam logic [3:0] ALU_BNE   = 4'b1001;
  localparam logic [3:0] ALU_SLT   = 4'b1100;
  localparam logic [3:0] ALU_BGE   = 4'b1101;
  localparam logic [3:0] ALU_SLTU  = 4'b1110;
  localparam logic [3:0] ALU_BGEU  = 4'b1111;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2 = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;
  localparam logic [1:0] SRCB_4   = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

endpackage

// File: rtl/alu_decoder.sv
// Maps {op class, funct3, funct7[5]} to the ALU operation code
// and flags encodings that are not RV32I instructions.
module alu_decoder
  import ctrl_pkg::*;
(
  input  op_class_t  cls_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output logic [3:0] alu_ctrl_o,
  output logic       illegal_o
);

  logic is_r;

  assign is_r = (cls_i == CLS_R);

  always_comb begin
    alu_ctrl_o = ALU_ADD;
    illegal_o  = 1'b0;
    unique case (cls_i)
      CLS_R, CLS_I: begin
        unique case (funct3_i)
          3'b000: alu_ctrl_o = (is_r && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b001: alu_ctrl_o = ALU_SLL;
          3'b010: alu_ctrl_o = ALU_SLT;
          3'b011: alu_ctrl_o = ALU_SLTU;
          3'b100: alu_ctrl_o = ALU_XOR;
          3'b101: alu_ctrl_o = funct7b5_i ? ALU_SRA : ALU_SRL;
          3'b110: alu_ctrl_o = ALU_OR;
          3'b111: alu_ctrl_o = ALU_AND;
        endcase
        // For I-type, funct7[5] is an immediate bit except on shifts
        if (funct7b5_i) begin
          if (is_r)
            illegal_o = !(funct3_i inside {3'b000, 3'b101});
          else
            illegal_o = (funct3_i == 3'b001);
        end
      end
      CLS_BR: begin
        unique case (funct3_i)
          3'b000: alu_ctrl_o = ALU_SUB;
          3'b001: alu_ctrl_o = ALU_BNE;
          3'b100: alu_ctrl_o = ALU_SLT;
          3'b101: alu_ctrl_o = ALU_BGE;
          3'b110: alu_ctrl_o = ALU_SLTU;
          3'b111: alu_ctrl_o = ALU_BGEU;
          default: illegal_o = 1'b1;
        endcase
      end
      CLS_ADD: alu_ctrl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I main controller: sequences fetch, decode,
// execute, memory and writeback over a valid/ack memory port.
module mc_control_fsm
  import ctrl_pkg::*;
#(
  parameter int W      = 32,
  parameter int ACK_TO = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] Instr,
  input  logic         flag,
  input  logic         MemAck,
  output logic         MemReq,
  output logic         MemWrite,
  output logic         AdrSrc,
  output logic         IRWrite,
  output logic         PCWrite,
  output logic         RegWrite,
  output logic [1:0]   ALUSrcA,
  output logic [1:0]   ALUSrcB,
  output logic [1:0]   ResultSrc,
  output logic [2:0]   ImmSrc,
  output logic [3:0]   ALUctrl,
  output logic         Trap
);

  localparam int CW = (ACK_TO > 1) ? $clog2(ACK_TO + 1) : 1;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       unused_instr;

  assign opc = Instr[6:0];
  assign f3  = Instr[14:12];
  assign f7  = Instr[31:25];
  assign unused_instr = ^{Instr[24:15], Instr[11:7]};

  op_class_t  cls;
  logic [3:0] dec_alu;
  logic       dec_ill;
  logic       is_shi;
  logic       f7_bad;
  logic       bad;

  always_comb begin
    cls = CLS_ADD;
    if (opc == OP_R)       cls = CLS_R;
    else if (opc == OP_I)  cls = CLS_I;
    else if (opc == OP_BR) cls = CLS_BR;
  end

  alu_decoder u_dec (
    .cls_i      (cls),
    .funct3_i   (f3),
    .funct7b5_i (f7[5]),
    .alu_ctrl_o (dec_alu),
    .illegal_o  (dec_ill)
  );

  assign is_shi = (opc == OP_I) && (f3 inside {3'b001, 3'b101});
  assign f7_bad = ((opc == OP_R) || is_shi)
               && (f7 != 7'b0000000) && (f7 != 7'b0100000);
  assign bad    = dec_ill || f7_bad;

  logic       mreq, mwr, adr, irw, pcw, rw, trp;
  logic [1:0] srca, srcb, res;
  logic [2:0] imm;
  logic [3:0] alu;
  logic       waiting, to_hit;

  assign waiting = mreq && !MemAck;
  assign to_hit  = (ACK_TO != 0) && waiting
                && (cnt_q == CW'(ACK_TO - 1));
  assign cnt_d   = waiting ? cnt_q + 1'b1 : '0;

  always_comb begin
    state_d = state_q;
    mreq = 1'b0;
    mwr  = 1'b0;
    adr  = 1'b0;
    irw  = 1'b0;
    pcw  = 1'b0;
    rw   = 1'b0;
    trp  = 1'b0;
    srca = SRCA_PC;
    srcb = SRCB_RS2;
    res  = RES_ALUOUT;
    imm  = IMM_I;
    alu  = ALU_ADD;
    unique case (state_q)
      S_FETCH: begin
        mreq = 1'b1;
        srcb = SRCB_4;
        res  = RES_ALU;
        if (MemAck) begin
          irw = 1'b1;
          pcw = 1'b1;
          state_d = S_DECODE;
        end else if (to_hit) begin
          state_d = S_TRAP;
        end
      end
      S_DECODE: begin
        srca = SRCA_OLDPC;
        srcb = SRCB_IMM;
        imm  = IMM_B;
        unique case (1'b1)
          opc == OP_LOAD,
          opc == OP_STORE: state_d = S_MEMADR;
          opc == OP_R:     state_d = bad ? S_TRAP : S_EXECR;
          opc == OP_I:     state_d = bad ? S_TRAP : S_EXECI;
          opc == OP_BR:    state_d = bad ? S_TRAP : S_BRANCH;
          opc == OP_JAL:   state_d = S_JAL;
          opc == OP_JALR:  state_d = S_JALR;
          opc == OP_LUI:   state_d = S_LUI;
          opc == OP_AUIPC: state_d = S_AUIPC;
          default:         state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        srca = SRCA_RS1;
        srcb = SRCB_IMM;
        imm  = opc[5] ? IMM_S : IMM_I;
        state_d = opc[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mreq = 1'b1;
        adr  = 1'b1;
        if (MemAck)      state_d = S_MEMWB;
        else if (to_hit) state_d = S_TRAP;
      end
      S_MEMWB: begin
        rw  = 1'b1;
        res = RES_DATA;
        state_d = S_FETCH;
      end
      S_MEMWRITE: begin
        mreq = 1'b1;
        mwr  = 1'b1;
        adr  = 1'b1;
        if (MemAck)      state_d = S_FETCH;
        else if (to_hit) state_d = S_TRAP;
      end
      S_EXECR: begin
        srca = SRCA_RS1;
        alu  = dec_alu;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        srca = SRCA_RS1;
        srcb = SRCB_IMM;
        alu  = dec_alu;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        rw = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        srca = SRCA_RS1;
        alu  = dec_alu;
        pcw  = flag;
        state_d = S_FETCH;
      end
      S_JAL: begin
        srca = SRCA_OLDPC;
        srcb = SRCB_IMM;
        imm  = IMM_J;
        state_d = S_JWB;
      end
      S_JALR: begin
        srca = SRCA_RS1;
        srcb = SRCB_IMM;
        state_d = S_JWB;
      end
      S_JWB: begin
        // target from ALUOut; link value OldPC+4 on the ALU path
        rw   = 1'b1;
        pcw  = 1'b1;
        srca = SRCA_OLDPC;
        srcb = SRCB_4;
        state_d = S_FETCH;
      end
      S_LUI: begin
        srcb = SRCB_IMM;
        imm  = IMM_U;
        alu  = ALU_PASSB;
        state_d = S_ALUWB;
      end
      S_AUIPC: begin
        srca = SRCA_OLDPC;
        srcb = SRCB_IMM;
        imm  = IMM_U;
        state_d = S_ALUWB;
      end
      S_TRAP: trp = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset forces every output low without waiting for a clock
  assign MemReq    = rst_n & mreq;
  assign MemWrite  = rst_n & mwr;
  assign AdrSrc    = rst_n & adr;
  assign IRWrite   = rst_n & irw;
  assign PCWrite   = rst_n & pcw;
  assign RegWrite  = rst_n & rw;
  assign Trap      = rst_n & trp;
  assign ALUSrcA   = rst_n ? srca : '0;
  assign ALUSrcB   = rst_n ? srcb : '0;
  assign ResultSrc = rst_n ? res  : '0;
  assign ImmSrc    = rst_n ? imm  : '0;
  assign ALUctrl   = rst_n ? alu  : '0;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: per-cycle expectations are
// queued with the stimulus and compared against the outputs.
module tb_mc_control_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] Instr = '0;
  logic [31:0] Instr2 = 32'h00500093;
  logic        flag = 1'b0;
  logic        MemAck = 1'b0;
  logic        MemAck2 = 1'b0;

  logic       MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [2:0] ImmSrc;
  logic [3:0] ALUctrl;
  logic       Trap;

  logic       MemReq2, MemWrite2, AdrSrc2, IRWrite2, PCWrite2;
  logic       RegWrite2;
  logic [1:0] ALUSrcA2, ALUSrcB2, ResultSrc2;
  logic [2:0] ImmSrc2;
  logic [3:0] ALUctrl2;
  logic       Trap2;

  always #5 clk = ~clk;

  mc_control_fsm u_dut (
    .clk(clk), .rst_n(rst_n), .Instr(Instr), .flag(flag),
    .MemAck(MemAck), .MemReq(MemReq), .MemWrite(MemWrite),
    .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUctrl(ALUctrl),
    .Trap(Trap)
  );

  mc_control_fsm #(.W(32), .ACK_TO(4)) u_to (
    .clk(clk), .rst_n(rst_n), .Instr(Instr2), .flag(1'b0),
    .MemAck(MemAck2), .MemReq(MemReq2), .MemWrite(MemWrite2),
    .AdrSrc(AdrSrc2), .IRWrite(IRWrite2), .PCWrite(PCWrite2),
    .RegWrite(RegWrite2), .ALUSrcA(ALUSrcA2), .ALUSrcB(ALUSrcB2),
    .ResultSrc(ResultSrc2), .ImmSrc(ImmSrc2), .ALUctrl(ALUctrl2),
    .Trap(Trap2)
  );

  localparam int F_TRAP = 0;
  localparam int F_ALU  = 1;
  localparam int F_IMM  = 5;
  localparam int F_RES  = 8;
  localparam int F_SRCB = 10;
  localparam int F_SRCA = 12;
  localparam int F_STRB = 14;
  localparam int F_IRW  = 16;
  localparam int F_MR   = 19;

  localparam logic [31:0] I_SUB   = 32'h402081B3;
  localparam logic [31:0] I_BEQ   = 32'h00208063;
  localparam logic [31:0] I_BGEU  = 32'h0020F063;
  localparam logic [31:0] I_BLTU  = 32'h0020E063;
  localparam logic [31:0] I_BR010 = 32'h0020A063;
  localparam logic [31:0] I_LW    = 32'h0000A283;
  localparam logic [31:0] I_SW    = 32'h0050A023;
  localparam logic [31:0] I_ADDI  = 32'h00500093;
  localparam logic [31:0] I_SRAI  = 32'h4050D093;
  localparam logic [31:0] I_LUI   = 32'h123450B7;
  localparam logic [31:0] I_AUIPC = 32'h00001097;
  localparam logic [31:0] I_JAL   = 32'h008000EF;
  localparam logic [31:0] I_BADOP = 32'h0000007F;
  localparam logic [31:0] I_MUL   = 32'h022081B3;

  typedef struct {
    string tag;
    int    dut;
    int    lsb;
    int    w;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] obs(input int d);
    if (d == 0)
      return {MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
              ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUctrl, Trap};
    return {MemReq2, MemWrite2, AdrSrc2, IRWrite2, PCWrite2, RegWrite2,
            ALUSrcA2, ALUSrcB2, ResultSrc2, ImmSrc2, ALUctrl2, Trap2};
  endfunction

  function automatic void ex(input string tag, input int lsb,
                             input int w, input int val,
                             input int d = 0);
    exp_t e;
    e.tag = tag;
    e.dut = d;
    e.lsb = lsb;
    e.w   = w;
    e.val = val;
    sb.push_back(e);
  endfunction

  task automatic cyc();
    exp_t        e;
    logic [19:0] o;
    logic [19:0] m;
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.dut);
      m = (20'd1 << e.w) - 20'd1;
      check(e.tag, 32'((o >> e.lsb) & m), 32'(e.val));
    end
    @(negedge clk);
  endtask

  task automatic do_fetch(input logic [31:0] ins, input int lat);
    for (int i = 0; i < lat; i++) begin
      MemAck = 1'b0;
      ex("fetch_wait", F_STRB, 6, 6'b100000);
      cyc();
    end
    MemAck = 1'b1;
    Instr  = ins;
    ex("fetch_ack", F_STRB, 6, 6'b100110);
    ex("fetch_srca", F_SRCA, 2, 0);
    ex("fetch_srcb", F_SRCB, 2, 2);
    ex("fetch_res", F_RES, 2, 2);
    ex("fetch_alu", F_ALU, 4, 0);
    cyc();
    MemAck = 1'b0;
    ex("dec_strb", F_STRB, 6, 0);
    ex("dec_srca", F_SRCA, 2, 1);
    ex("dec_srcb", F_SRCB, 2, 1);
    ex("dec_imm", F_IMM, 3, 2);
    ex("dec_alu", F_ALU, 4, 0);
    cyc();
  endtask

  task automatic alu_wb();
    ex("aluwb_strb", F_STRB, 6, 6'b000001);
    ex("aluwb_res", F_RES, 2, 0);
    cyc();
  endtask

  task automatic branch(input logic [31:0] ins, input logic f,
                        input int code);
    do_fetch(ins, 0);
    flag = f;
    ex("br_strb", F_STRB, 6, f ? 6'b000010 : 6'b000000);
    ex("br_alu", F_ALU, 4, code);
    ex("br_srca", F_SRCA, 2, 2);
    ex("br_srcb", F_SRCB, 2, 0);
    ex("br_res", F_RES, 2, 0);
    cyc();
    flag = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ex("rst_strb", F_STRB, 6, 0);
    ex("rst_trap", F_TRAP, 1, 0);
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic illegal(input logic [31:0] ins);
    do_fetch(ins, 0);
    for (int i = 0; i < 3; i++) begin
      MemAck = i[0];
      ex("trap_flag", F_TRAP, 1, 1);
      ex("trap_strb", F_STRB, 6, 0);
      cyc();
    end
    MemAck = 1'b0;
    do_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ex("rst_strb", F_STRB, 6, 0);
    ex("rst_sel", F_RES, 6, 0);
    ex("rst_imm", F_IMM, 3, 0);
    ex("rst_alu", F_ALU, 4, 0);
    ex("rst_trap", F_TRAP, 1, 0);
    ex("rst_trap_to", F_TRAP, 1, 0, 1);
    cyc();
    cyc();
    rst_n = 1'b1;

    do_fetch(I_SUB, 2);
    ex("execr_strb", F_STRB, 6, 0);
    ex("execr_alu", F_ALU, 4, 4'b1000);
    ex("execr_srca", F_SRCA, 2, 2);
    ex("execr_srcb", F_SRCB, 2, 0);
    cyc();
    alu_wb();

    branch(I_BEQ, 1'b1, 4'b1000);
    branch(I_BEQ, 1'b0, 4'b1000);
    branch(I_BGEU, 1'b1, 4'b1111);
    branch(I_BLTU, 1'b0, 4'b1110);

    do_fetch(I_LW, 0);
    ex("ld_adr_strb", F_STRB, 6, 0);
    ex("ld_adr_srca", F_SRCA, 2, 2);
    ex("ld_adr_srcb", F_SRCB, 2, 1);
    ex("ld_adr_imm", F_IMM, 3, 0);
    cyc();
    for (int i = 0; i < 3; i++) begin
      MemAck = (i == 2);
      ex("memread_strb", F_STRB, 6, 6'b101000);
      cyc();
    end
    MemAck = 1'b0;
    ex("memwb_strb", F_STRB, 6, 6'b000001);
    ex("memwb_res", F_RES, 2, 1);
    cyc();

    do_fetch(I_SW, 0);
    ex("st_adr_strb", F_STRB, 6, 0);
    ex("st_adr_imm", F_IMM, 3, 1);
    cyc();
    for (int i = 0; i < 3; i++) begin
      MemAck = (i == 2);
      ex("memwrite_strb", F_STRB, 6, 6'b111000);
      cyc();
    end
    MemAck = 1'b0;

    do_fetch(I_ADDI, 0);
    ex("addi_alu", F_ALU, 4, 0);
    ex("addi_srcb", F_SRCB, 2, 1);
    ex("addi_strb", F_STRB, 6, 0);
    cyc();
    alu_wb();

    do_fetch(I_SRAI, 0);
    ex("srai_alu", F_ALU, 4, 4'b0111);
    cyc();
    alu_wb();

    do_fetch(I_LUI, 0);
    ex("lui_srcb", F_SRCB, 2, 1);
    ex("lui_imm", F_IMM, 3, 3);
    ex("lui_alu", F_ALU, 4, 4'b0001);
    cyc();
    alu_wb();

    do_fetch(I_AUIPC, 0);
    ex("auipc_srca", F_SRCA, 2, 1);
    ex("auipc_imm", F_IMM, 3, 3);
    ex("auipc_alu", F_ALU, 4, 0);
    cyc();
    alu_wb();

    do_fetch(I_JAL, 0);
    ex("jal_imm", F_IMM, 3, 4);
    ex("jal_srca", F_SRCA, 2, 1);
    ex("jal_strb", F_STRB, 6, 0);
    cyc();
    ex("jwb_strb", F_STRB, 6, 6'b000011);
    cyc();

    illegal(I_BADOP);
    illegal(I_MUL);
    illegal(I_BR010);

    do_fetch(I_LW, 0);
    cyc();
    ex("mr_wait", F_STRB, 6, 6'b101000);
    cyc();
    #1;
    rst_n = 1'b0;
    ex("async_strb", F_STRB, 6, 0);
    ex("async_trap", F_TRAP, 1, 0);
    cyc();
    rst_n = 1'b1;
    do_fetch(I_ADDI, 1);
    cyc();
    alu_wb();

    do_reset();
    for (int i = 0; i < 4; i++) begin
      ex("to_req", F_MR, 1, 1, 1);
      ex("to_notrap", F_TRAP, 1, 0, 1);
      cyc();
    end
    ex("to_trap", F_TRAP, 1, 1, 1);
    ex("to_strb", F_STRB, 6, 0, 1);
    cyc();

    do_reset();
    for (int i = 0; i < 4; i++) begin
      MemAck2 = (i == 3);
      ex("ackwin_req", F_MR, 1, 1, 1);
      cyc();
    end
    MemAck2 = 1'b0;
    ex("ackwin_trap", F_TRAP, 1, 0, 1);
    ex("ackwin_dec", F_SRCA, 2, 1, 1);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
